seq_multiplier: RTL and testbench

Parametrised iterative shift-add multiplier, the successor to the fixed 8x8 `multiplier`. It adds generic operand width, a configurable number of multiplier bits retired per cycle, per-transaction signed/unsigned mode, and a full valid/ready input handshake. It sits in the `multiplier` example datapath and is driven by a self-checking bench that issues random operand pairs.

---
 rtl/multiplier_pkg.sv | 7 +
 rtl/mult_step.sv | 11 +
 rtl/seq_multiplier.sv | 87 ++++++++
 tb/tb_seq_multiplier.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/multiplier_pkg.sv
// multiplier_pkg: shared FSM state type and sizing helper for the iterative multiplier.
package multiplier_pkg;
    typedef enum logic [1:0] {IDLE, BUSY, DONE} mult_state_t;
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction
endpackage

// File: rtl/mult_step.sv
// mult_step: combinational partial product of a magnitude and a few multiplier bits.
module mult_step #(
    parameter int WIDTH = 8,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic [WIDTH:0]                    mag_i,
    input  logic [BITS_PER_CYCLE-1:0]         bits_i,
    output logic [WIDTH+BITS_PER_CYCLE:0]     psum_o
);
    assign psum_o = {{BITS_PER_CYCLE{1'b0}}, mag_i} * {{(WIDTH+1){1'b0}}, bits_i};
endmodule

// File: rtl/seq_multiplier.sv
// seq_multiplier: iterative shift-add multiplier, BITS_PER_CYCLE multiplier bits retired per cycle.
module seq_multiplier
    import multiplier_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    input  logic                 in_signed,
    input  logic                 in_vld,
    output logic                 in_rdy,
    output logic [2*WIDTH-1:0]   res,
    output logic                 res_vld
);
    localparam int N  = WIDTH / BITS_PER_CYCLE;
    localparam int CW = cnt_width(N);
    localparam int PW = WIDTH + BITS_PER_CYCLE + 1;
    if (WIDTH % BITS_PER_CYCLE != 0) begin : g_bad_bpc
        $error("BITS_PER_CYCLE must divide WIDTH");
    end
    mult_state_t state_q, state_d;
    logic [WIDTH:0] a_q, a_d, b_q, b_d, a_ext, b_ext;
    logic sign_q, sign_d, accept;
    logic [2*WIDTH-1:0] acc_q, acc_d, res_q, res_d, sum;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [PW-1:0] pp;
    mult_step #(.WIDTH(WIDTH), .BITS_PER_CYCLE(BITS_PER_CYCLE)) u_step (
        .mag_i  (a_q),
        .bits_i (b_q[BITS_PER_CYCLE-1:0]),
        .psum_o (pp)
    );
    // Extra top bit lets -2^(WIDTH-1) keep its full magnitude after negation.
    assign a_ext   = {in_signed & in_a[WIDTH-1], in_a};
    assign b_ext   = {in_signed & in_b[WIDTH-1], in_b};
    assign sum     = acc_q + ((2*WIDTH)'(pp) << ((N - int'(cnt_q)) * BITS_PER_CYCLE));
    assign in_rdy  = state_q != BUSY;
    assign res_vld = state_q == DONE;
    assign res     = res_q;
    assign accept  = in_vld && in_rdy;
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sign_d  = sign_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        if (accept) begin
            state_d = BUSY;
            a_d     = a_ext[WIDTH] ? -a_ext : a_ext;
            b_d     = b_ext[WIDTH] ? -b_ext : b_ext;
            sign_d  = a_ext[WIDTH] ^ b_ext[WIDTH];
            acc_d   = '0;
            cnt_d   = CW'(N);
        end else if (state_q == BUSY) begin
            acc_d = sum;
            b_d   = b_q >> BITS_PER_CYCLE;
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
                state_d = DONE;
                res_d   = sign_q ? -sum : sum;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sign_q  <= 1'b0;
            acc_q   <= '0;
            cnt_q   <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sign_q  <= sign_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
        end
    end
endmodule

// File: tb/tb_seq_multiplier.sv
// tb_seq_multiplier: random and directed checks of two seq_multiplier configurations against a latency/product model.
module tb_seq_multiplier;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    logic [15:0] a[2], b[2];
    logic sg[2], vld[2];
    logic rdy0, rv0, rdy1, rv1;
    logic [15:0] res0;
    logic [31:0] res1;
    logic rdy_w[2], rv_w[2];
    logic [31:0] res_w[2];
    int errors = 0, checks = 0, last_busy = 0;
    bit armed = 0;
    int m_rem[2];
    logic m_vld[2];
    logic [31:0] m_res[2], m_pend[2];
    seq_multiplier #(.WIDTH(8), .BITS_PER_CYCLE(1)) dut0 (
        .clk(clk), .rst(rst), .in_a(a[0][7:0]), .in_b(b[0][7:0]), .in_signed(sg[0]),
        .in_vld(vld[0]), .in_rdy(rdy0), .res(res0), .res_vld(rv0));
    seq_multiplier #(.WIDTH(16), .BITS_PER_CYCLE(4)) dut1 (
        .clk(clk), .rst(rst), .in_a(a[1]), .in_b(b[1]), .in_signed(sg[1]),
        .in_vld(vld[1]), .in_rdy(rdy1), .res(res1), .res_vld(rv1));
    assign rdy_w[0] = rdy0;
    assign rdy_w[1] = rdy1;
    assign rv_w[0]  = rv0;
    assign rv_w[1]  = rv1;
    assign res_w[0] = {16'h0, res0};
    assign res_w[1] = res1;
    function automatic logic [31:0] ref_mul(input logic [15:0] x, input logic [15:0] y, input logic s, input int w);
        longint xa, ya, mask;
        mask = (longint'(1) << w) - 1;
        xa = longint'(x) & mask;
        ya = longint'(y) & mask;
        if (s && x[w-1]) xa -= longint'(1) << w;
        if (s && y[w-1]) ya -= longint'(1) << w;
        return 32'((xa * ya) & ((longint'(1) << (2 * w)) - 1));
    endfunction
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask
    // Model: a product appears N cycles after acceptance; ready whenever nothing is in flight.
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                m_rem[k] <= 0;
                m_vld[k] <= 1'b0;
                m_res[k] <= '0;
            end else if (vld[k] && m_rem[k] == 0) begin
                m_rem[k]  <= (k == 0) ? 8 : 4;
                m_vld[k]  <= 1'b0;
                m_pend[k] <= ref_mul(a[k], b[k], sg[k], (k == 0) ? 8 : 16);
            end else if (m_rem[k] != 0) begin
                m_rem[k] <= m_rem[k] - 1;
                if (m_rem[k] == 1) begin
                    m_res[k] <= m_pend[k];
                    m_vld[k] <= 1'b1;
                end
            end
        end
    end
    always @(negedge clk) begin
        if (armed) begin
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("in_rdy%0d", k), 32'(rdy_w[k]), 32'(m_rem[k] == 0));
                chk($sformatf("res_vld%0d", k), 32'(rv_w[k]), 32'(m_vld[k]));
                chk($sformatf("res%0d", k), res_w[k], m_res[k]);
            end
        end
    end
    task automatic op(input int k, input logic [15:0] x, input logic [15:0] y, input logic s, output int lat);
        int n;
        n = 0;
        while (!rdy_w[k] && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!rdy_w[k]) chk("rdy_timeout", 32'(rdy_w[k]), 32'd1);
        a[k] = x; b[k] = y; sg[k] = s; vld[k] = 1'b1;
        @(negedge clk);
        vld[k] = 1'b0;
        lat = 0;
        last_busy = rdy_w[k] ? 0 : 1;
        while (!rv_w[k] && lat < 40) begin
            @(negedge clk);
            lat++;
            if (!rdy_w[k]) last_busy++;
        end
        if (!rv_w[k]) chk("done_timeout", 32'(rv_w[k]), 32'd1);
    endtask
    initial begin
        int lat;
        logic [15:0] x, y;
        logic s;
        for (int k = 0; k < 2; k++) begin
            a[k] = '0; b[k] = '0; sg[k] = 1'b0; vld[k] = 1'b0;
        end
        repeat (2) @(negedge clk);
        armed = 1;
        chk("reset_rdy", 32'(rdy0), 32'd1);
        chk("reset_vld", 32'(rv0), 32'd0);
        chk("reset_res", 32'(res0), 32'd0);
        rst = 1'b0;
        op(0, 16'd13, 16'd11, 1'b0, lat);
        chk("lat_13x11", lat, 8);
        chk("busy_13x11", last_busy, 8);
        chk("res_13x11", 32'(res0), 32'd143);
        op(0, 16'hFF, 16'hFF, 1'b0, lat);
        chk("u_ff_ff", 32'(res0), 32'hFE01);
        op(0, 16'hFF, 16'hFF, 1'b1, lat);
        chk("s_m1_m1", 32'(res0), 32'h0001);
        op(0, 16'hFD, 16'h05, 1'b1, lat);
        chk("s_m3_5", 32'(res0), 32'hFFF1);
        op(0, 16'h80, 16'h80, 1'b1, lat);
        chk("s_m128_m128", 32'(res0), 32'h4000);
        // Back-to-back accept in DONE, holding in_vld into BUSY.
        a[0] = 16'd7; b[0] = 16'd9; sg[0] = 1'b0; vld[0] = 1'b1;
        @(negedge clk);
        chk("b2b_vld_drop", 32'(rv0), 32'd0);
        chk("b2b_res_held", 32'(res0), 32'h4000);
        repeat (3) @(negedge clk);
        chk("b2b_res_still_held", 32'(res0), 32'h4000);
        vld[0] = 1'b0;
        lat = 0;
        while (!rv0 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk("b2b_res", 32'(res0), 32'd63);
        // Reset in the middle of BUSY, with in_vld coincident with rst.
        a[0] = 16'd200; b[0] = 16'd100; vld[0] = 1'b1;
        @(negedge clk);
        vld[0] = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1; vld[0] = 1'b1; a[0] = 16'd1; b[0] = 16'd1;
        @(negedge clk);
        rst = 1'b0; vld[0] = 1'b0;
        chk("rst_rdy", 32'(rdy0), 32'd1);
        chk("rst_vld", 32'(rv0), 32'd0);
        chk("rst_res", 32'(res0), 32'd0);
        @(negedge clk);
        chk("rst_no_accept", 32'(rdy0), 32'd1);
        op(0, 16'd7, 16'd9, 1'b0, lat);
        chk("post_rst_res", 32'(res0), 32'd63);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("hold_vld", 32'(rv0), 32'd1);
            chk("hold_res", 32'(res0), 32'd63);
        end
        op(1, 16'h8000, 16'h8000, 1'b1, lat);
        chk("w16_min_sq", res1, 32'h4000_0000);
        op(1, 16'hFFFF, 16'hFFFF, 1'b0, lat);
        chk("w16_u_max_sq", res1, 32'hFFFE_0001);
        for (int i = 0; i < 1000; i++) begin
            x = 16'($urandom); y = 16'($urandom); s = 1'($urandom);
            if ($urandom_range(0, 9) == 0) x = 16'h8000;
            if ($urandom_range(0, 9) == 0) y = 16'h0;
            op(1, x, y, s, lat);
            chk("w16_lat", lat, 4);
            chk("w16_res", res1, ref_mul(x, y, s, 16));
        end
        for (int i = 0; i < 200; i++) begin
            x = 16'($urandom_range(0, 255)); y = 16'($urandom_range(0, 255)); s = 1'($urandom);
            op(0, x, y, s, lat);
            chk("w8_lat", lat, 8);
        end
        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end
endmodule
